// File: rtl/display_pkg.sv
// Shared types, glyph table and sizing helpers for the register display.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        UPDATE
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit0 = seg a ... bit6 = seg g.
    function automatic logic [6:0] seg7_lut(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ceil(width * log10(2)) with a fixed-point log10(2).
    function automatic int dec_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift/add-3 step per cycle, DATA_W steps.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEC_DIGITS = dec_digits(DATA_W)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [DATA_W-1:0]       i_bin,
    output logic [4*DEC_DIGITS-1:0] o_bcd,
    output logic                    o_done
);

    localparam int BW = 4 * DEC_DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (i_start) begin
            bin_d = i_bin;
            bcd_d = '0;
            cnt_d = CW'(DATA_W);
        end else if (cnt_q != '0) begin
            {bcd_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_bcd  = bcd_q;
    // High during the last step; the result is final on the next cycle.
    assign o_done = (cnt_q == CW'(1));

endmodule

// File: rtl/reg_display_ctrl.sv
// Register-bus viewer: selects a word and shows it in hex or decimal
// on paged active-low seven-segment digits.
module reg_display_ctrl
    import display_pkg::*;
#(
    parameter  int NUM_REGS    = 32,
    parameter  int DATA_W      = 32,
    parameter  int NUM_DIGITS  = 4,
    parameter  int REFRESH_DIV = 50000,
    localparam int SEL_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REGS*DATA_W-1:0]   i_regs,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic                         i_mode,
    input  logic [2:0]                   i_page,
    output logic [NUM_DIGITS*7-1:0]      o_hex,
    output logic [NUM_DIGITS-1:0]        o_dp,
    output logic                         o_busy
);

    localparam int HEX_DIGITS = DATA_W / 4;
    localparam int DEC_DIGITS = dec_digits(DATA_W);
    localparam int MAXG       = 8 * NUM_DIGITS;
    localparam int GW         = $clog2(MAXG);
    localparam int HEX_N      = (HEX_DIGITS < MAXG) ? HEX_DIGITS : MAXG;
    localparam int DEC_N      = (DEC_DIGITS < MAXG) ? DEC_DIGITS : MAXG;
    localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CTRL_W     = SEL_W + 4;

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0]       ctrl_q, ctrl_now;
    logic [DATA_W-1:0]       word_q, word_d, word_mux;
    logic                    mode_q, mode_d;
    logic [2:0]              page_q, page_d;
    logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;

    logic                    wrap, trig, latch, start, upd, done;
    logic [4*DEC_DIGITS-1:0] bcd;
    logic [DEC_DIGITS-1:0]   shown;
    logic                    nz;
    logic [6:0]              glyph [MAXG];

    // Out-of-range selects never match and fall back to word 0.
    always_comb begin
        word_mux = i_regs[DATA_W-1:0];
        for (int k = 1; k < NUM_REGS; k++) begin
            if (i_sel == SEL_W'(k))
                word_mux = i_regs[k*DATA_W +: DATA_W];
        end
    end

    assign ctrl_now = {i_sel, i_mode, i_page};
    assign wrap     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign trig     = wrap | (ctrl_now != ctrl_q);
    assign cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | trig;
        latch     = 1'b0;
        start     = 1'b0;
        upd       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q | trig) begin
                    latch     = 1'b1;
                    pending_d = 1'b0;
                    state_d   = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mode_q) begin
                    start   = 1'b1;
                    state_d = CONVERT;
                end else begin
                    state_d = UPDATE;
                end
            end
            CONVERT: begin
                if (done)
                    state_d = UPDATE;
            end
            UPDATE: begin
                upd     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_d = latch ? word_mux : word_q;
    assign mode_d = latch ? i_mode   : mode_q;
    assign page_d = latch ? i_page   : page_q;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .DEC_DIGITS (DEC_DIGITS)
    ) u_bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (start),
        .i_bin   (word_q),
        .o_bcd   (bcd),
        .o_done  (done)
    );

    // Digit g is shown if it or any higher digit is non-zero; digit 0 always.
    always_comb begin
        nz    = 1'b0;
        shown = '0;
        for (int g = DEC_DIGITS - 1; g >= 0; g--) begin
            nz       = nz | (|bcd[g*4 +: 4]);
            shown[g] = nz | (g == 0);
        end
    end

    always_comb begin
        for (int g = 0; g < MAXG; g++)
            glyph[g] = SEG_BLANK;
        if (mode_q) begin
            for (int g = 0; g < DEC_N; g++) begin
                if (shown[g])
                    glyph[g] = seg7_lut(bcd[g*4 +: 4]);
            end
        end else begin
            for (int g = 0; g < HEX_N; g++)
                glyph[g] = seg7_lut(word_q[g*4 +: 4]);
        end
    end

    always_comb begin
        hex_d = hex_q;
        dp_d  = dp_q;
        if (upd) begin
            dp_d = '1;
            for (int d = 0; d < NUM_DIGITS; d++)
                hex_d[d*7 +: 7] = glyph[GW'(int'(page_q) * NUM_DIGITS + d)];
            if (page_q != 3'd0)
                dp_d[0] = 1'b0;
            if (mode_q)
                dp_d[NUM_DIGITS-1] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b1;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            word_q    <= '0;
            mode_q    <= 1'b0;
            page_q    <= '0;
            hex_q     <= '1;
            dp_q      <= '1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_now;
            word_q    <= word_d;
            mode_q    <= mode_d;
            page_q    <= page_d;
            hex_q     <= hex_d;
            dp_q      <= dp_d;
        end
    end

    assign o_hex  = hex_q;
    assign o_dp   = dp_q;
    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_display_ctrl.sv
// Random and directed checks of reg_display_ctrl against a digit-level model.
module tb_reg_display_ctrl;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int ND = 4;
    localparam int RD = 64;

    localparam logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*DW-1:0]  regs;
    logic [4:0]        sel;
    logic              mode;
    logic [2:0]        page;
    logic [ND*7-1:0]   hex;
    logic [ND-1:0]     dp;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_display_ctrl #(
        .NUM_REGS    (NR),
        .DATA_W      (DW),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_regs  (regs),
        .i_sel   (sel),
        .i_mode  (mode),
        .i_page  (page),
        .o_hex   (hex),
        .o_dp    (dp),
        .o_busy  (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {dp, hex} for a word shown in a given mode and page.
    function automatic logic [31:0] model(input logic [31:0] w,
                                          input logic m,
                                          input logic [2:0] p);
        int         val [32];
        longint     v;
        int         n;
        int         g;
        logic [27:0] h;
        logic [3:0]  d4;
        for (int i = 0; i < 32; i++) val[i] = -1;
        if (!m) begin
            for (int i = 0; i < 8; i++)
                val[i] = int'((w >> (4 * i)) & 32'hF);
        end else begin
            v = longint'(w);
            n = 0;
            do begin
                val[n] = int'(v % 10);
                v = v / 10;
                n++;
            end while (v > 0);
        end
        for (int d = 0; d < 4; d++) begin
            g = int'(p) * 4 + d;
            h[d*7 +: 7] = (val[g] >= 0) ? GLY[val[g]] : 7'h7F;
        end
        d4 = 4'hF;
        if (p != 3'd0) d4[0] = 1'b0;
        if (m) d4[3] = 1'b0;
        return {d4, h};
    endfunction

    function automatic logic [31:0] word(input int k);
        return regs[k*DW +: DW];
    endfunction

    function automatic logic [31:0] exp_now();
        return model(word(int'(sel)), mode, page);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    // Inputs were just applied in an idle cycle; check exact latency.
    task automatic timed(input string tag, input logic [31:0] prev,
                         input logic [31:0] cur, input int lat);
        int bc = 0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) bc += int'(busy);
            if (k == lat - 1) chk({tag, "_early"}, hex, prev[27:0]);
        end
        chk({tag, "_hex"}, hex, cur[27:0]);
        chk({tag, "_dp"}, dp, cur[31:28]);
        chk({tag, "_busy"}, bc, lat - 1);
    endtask

    initial begin
        logic [31:0] prev, cur, a, b;
        int tear;
        int n;

        rst_n = 1'b0;
        for (int k = 0; k < NR; k++) regs[k*DW +: DW] = $urandom;
        regs[1*DW +: DW] = 32'h1234ABCD;
        sel  = 5'd1;
        mode = 1'b0;
        page = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_hex", hex, 28'hFFFFFFF);
        chk("rst_dp", dp, 4'hF);
        chk("rst_busy", busy, 0);

        rst_n = 1'b1;
        prev = 32'hFFFFFFFF;
        cur  = exp_now();
        timed("hex_p0", prev, cur, 3);
        chk("abcd", hex, {7'h08, 7'h03, 7'h46, 7'h21});

        wait_idle();
        prev = cur;
        page = 3'd1;
        cur  = exp_now();
        timed("hex_p1", prev, cur, 3);
        chk("p1_dp0", dp, 4'hE);

        wait_idle();
        prev = cur;
        page = 3'd2;
        cur  = exp_now();
        timed("hex_p2", prev, cur, 3);
        chk("p2_blank", hex, 28'hFFFFFFF);

        regs[3*DW +: DW] = 32'hFFFFFFFF;
        for (int p = 0; p < 3; p++) begin
            wait_idle();
            prev = cur;
            sel  = 5'd3;
            mode = 1'b1;
            page = 3'(p);
            cur  = exp_now();
            timed($sformatf("dec_p%0d", p), prev, cur, 35);
            if (p == 0)
                chk("dec_7295", hex, {7'h78, 7'h24, 7'h10, 7'h12});
        end

        regs[4*DW +: DW] = 32'd0;
        wait_idle();
        prev = cur;
        sel  = 5'd4;
        page = 3'd0;
        cur  = exp_now();
        timed("dec_zero", prev, cur, 35);
        chk("zero_hex", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("zero_dp", dp, 4'h7);

        regs[5*DW +: DW] = 32'd987654321;
        regs[6*DW +: DW] = 32'd13579;
        a = model(word(5), 1'b1, 3'd0);
        b = model(word(6), 1'b1, 3'd0);
        wait_idle();
        prev = cur;
        sel  = 5'd5;
        tear = 0;
        for (int k = 1; k < 70; k++) begin
            @(negedge clk);
            if (k == 7) sel = 5'd6;
            if (k < 35 && hex !== prev[27:0]) tear++;
            if (k == 35) chk("first_pass", hex, a[27:0]);
            if (k > 35 && hex !== a[27:0]) tear++;
        end
        @(negedge clk);
        chk("second_pass", hex, b[27:0]);
        chk("no_tear", tear, 0);

        for (int r = 0; r < 2; r++) begin
            regs[6*DW +: DW] = $urandom;
            cur = exp_now();
            n = 0;
            while (hex !== cur[27:0] && n < RD + 35) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("refresh%0d", r), hex, cur[27:0]);
        end

        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < NR; k++) regs[k*DW +: DW] = $urandom;
            if (it % 4 == 0) regs[($urandom % NR)*DW +: DW] = $urandom_range(0, 99);
            sel  = 5'($urandom);
            mode = 1'($urandom);
            page = 3'($urandom_range(0, 7));
            repeat (100) @(negedge clk);
            cur = exp_now();
            chk($sformatf("rnd%0d_hex", it), hex, cur[27:0]);
            chk($sformatf("rnd%0d_dp", it), dp, cur[31:28]);
        end

        wait_idle();
        sel  = sel + 5'd1;
        mode = 1'b1;
        page = 3'd0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_hex", hex, 28'hFFFFFFF);
        chk("midrst_dp", dp, 4'hF);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        cur = exp_now();
        repeat (35) @(negedge clk);
        chk("post_rst_hex", hex, cur[27:0]);
        chk("post_rst_dp", dp, cur[31:28]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
